// File: rtl/dpram_core_if.sv
// dpram_core_if: bus bundle for the dual-port RAM (init/busy plus ports A and B)
interface dpram_core_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              init_req;
   logic              busy;
   logic              we_a;
   logic [ADDR_W-1:0] addr_a;
   logic [DATA_W-1:0] wdata_a;
   logic [DATA_W-1:0] rdata_a;
   logic              we_b;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] wdata_b;
   logic [DATA_W-1:0] rdata_b;
   logic              collision;
   modport master (
      output init_req, we_a, addr_a, wdata_a, we_b, addr_b, wdata_b,
      input  busy, rdata_a, rdata_b, collision
   );
   modport slave (
      input  init_req, we_a, addr_a, wdata_a, we_b, addr_b, wdata_b,
      output busy, rdata_a, rdata_b, collision
   );
endinterface

// File: rtl/dpram_core.sv
// dpram_core: dual-port RAM with self-clearing init sequence and write-collision handling
module dpram_core #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 8,
   parameter int WR_PRIO = 0,
   parameter int RD_MODE = 0
) (
   input logic         clk,
   input logic         rst_n,
   dpram_core_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {CLEAR, READY} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
   logic              coll_q, coll_d;
   logic              act, same, wr_a, wr_b, fwd_a, fwd_b;
   logic [DATA_W-1:0] win;
   logic [DATA_W-1:0] mem [DEPTH];
   // next state, clear counter, write arbitration and registered-read selection
   always_comb begin
      act       = state_q == READY && !bus.init_req;
      same      = bus.addr_a == bus.addr_b;
      coll_d    = act && bus.we_a && bus.we_b && same;
      wr_a      = act && bus.we_a && !(coll_d && WR_PRIO != 0);
      wr_b      = act && bus.we_b && !(coll_d && WR_PRIO != 1);
      win       = WR_PRIO == 1 ? bus.wdata_b : bus.wdata_a;
      fwd_a     = RD_MODE == 1 && act && bus.we_a && !(coll_d && WR_PRIO == 2);
      fwd_b     = RD_MODE == 1 && act && bus.we_b && !(coll_d && WR_PRIO == 2);
      rdata_a_d = !act ? '0 : fwd_a ? (coll_d ? win : bus.wdata_a) : mem[bus.addr_a];
      rdata_b_d = !act ? '0 : fwd_b ? (coll_d ? win : bus.wdata_b) : mem[bus.addr_b];
      state_d   = state_q == CLEAR ? (&cnt_q ? READY : CLEAR) : (bus.init_req ? CLEAR : READY);
      cnt_d     = state_q == CLEAR ? cnt_q + 1'b1 : '0;
   end
   // control and output registers, forced to the clearing state by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         coll_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
         coll_q    <= coll_d;
      end
   end
   // storage: one zero word per cycle while clearing, otherwise the arbitrated port writes
   always_ff @(posedge clk) begin
      if (state_q == CLEAR) begin
         mem[cnt_q] <= '0;
      end else begin
         if (wr_a) mem[bus.addr_a] <= bus.wdata_a;
         if (wr_b) mem[bus.addr_b] <= bus.wdata_b;
      end
   end
   assign bus.busy      = state_q == CLEAR;
   assign bus.rdata_a   = rdata_a_q;
   assign bus.rdata_b   = rdata_b_q;
   assign bus.collision = coll_q;
endmodule

// File: tb/tb_dpram_core.sv
// tb_dpram_core: scoreboard bench over three WR_PRIO/RD_MODE variants driven in lockstep
module tb_dpram_core;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   dpram_core_if i0 ();
   dpram_core_if i1 ();
   dpram_core_if i2 ();
   assign i1.init_req = i0.init_req;
   assign i1.we_a     = i0.we_a;
   assign i1.addr_a   = i0.addr_a;
   assign i1.wdata_a  = i0.wdata_a;
   assign i1.we_b     = i0.we_b;
   assign i1.addr_b   = i0.addr_b;
   assign i1.wdata_b  = i0.wdata_b;
   assign i2.init_req = i0.init_req;
   assign i2.we_a     = i0.we_a;
   assign i2.addr_a   = i0.addr_a;
   assign i2.wdata_a  = i0.wdata_a;
   assign i2.we_b     = i0.we_b;
   assign i2.addr_b   = i0.addr_b;
   assign i2.wdata_b  = i0.wdata_b;
   dpram_core #(.WR_PRIO(0), .RD_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
   dpram_core #(.WR_PRIO(1), .RD_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
   dpram_core #(.WR_PRIO(2), .RD_MODE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
   logic [7:0] ra [3];
   logic [7:0] rb [3];
   logic       co [3];
   logic       bz [3];
   assign ra[0] = i0.rdata_a;
   assign ra[1] = i1.rdata_a;
   assign ra[2] = i2.rdata_a;
   assign rb[0] = i0.rdata_b;
   assign rb[1] = i1.rdata_b;
   assign rb[2] = i2.rdata_b;
   assign co[0] = i0.collision;
   assign co[1] = i1.collision;
   assign co[2] = i2.collision;
   assign bz[0] = i0.busy;
   assign bz[1] = i1.busy;
   assign bz[2] = i2.busy;
   typedef struct packed {
      logic [7:0]      id;
      logic [2:0][7:0] ea;
      logic [2:0][7:0] eb;
      logic            ec;
   } exp_t;
   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] nid = 8'd0;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // one cycle of stimulus; expected outputs of u0/u1/u2 packed as {u2,u1,u0}
   task automatic op(input logic init, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                     input logic wb, input logic [7:0] ab, input logic [7:0] db,
                     input logic [23:0] ea, input logic [23:0] eb, input logic ec);
      exp_t e;
      @(negedge clk);
      i0.init_req = init;
      i0.we_a = wa; i0.addr_a = aa; i0.wdata_a = da;
      i0.we_b = wb; i0.addr_b = ab; i0.wdata_b = db;
      e.id = nid; e.ea = ea; e.eb = eb; e.ec = ec;
      nid++;
      q.push_back(e);
   endtask
   task automatic rst_chk(input string nm);
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("%s u%0d busy/coll/rdata", nm, k), {61'b0, bz[k], co[k], |{ra[k], rb[k]}}, 64'h4);
   endtask
   task automatic count_busy(input string nm);
      int n = 0;
      bit bad = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 200) i0.init_req = 1'b0;
         for (int k = 0; k < 3; k++)
            if (i0.busy && (bz[k] !== 1'b1 || co[k] !== 1'b0 || ra[k] !== 8'h00 || rb[k] !== 8'h00)) bad = 1'b1;
      end while (i0.busy && n < 400);
      i0.we_a = 1'b0; i0.we_b = 1'b0; i0.init_req = 1'b0;
      chk({nm, " busy cycles"}, 64'(n), 64'd256);
      chk({nm, " outputs during clear"}, 64'(bad), 64'd0);
   endtask
   // monitor: each queued entry matches the outputs registered at the edge after issue
   always @(posedge clk) begin : mon
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         #1;
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("op%0d rdata_a u%0d", e.id, k), 64'(ra[k]), 64'(e.ea[k]));
            chk($sformatf("op%0d rdata_b u%0d", e.id, k), 64'(rb[k]), 64'(e.eb[k]));
            chk($sformatf("op%0d collision u%0d", e.id, k), 64'(co[k]), 64'(e.ec));
         end
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end
   initial begin
      i0.init_req = 1'b0;
      i0.we_a = 1'b0; i0.addr_a = '0; i0.wdata_a = '0;
      i0.we_b = 1'b0; i0.addr_b = '0; i0.wdata_b = '0;
      #12;
      rst_chk("reset");
      @(negedge clk) rst_n = 1'b1;
      count_busy("power-up clear");
      op(0, 0, 8'h33, 8'h00, 0, 8'hFF, 8'h00, 24'h000000, 24'h000000, 0);
      op(0, 1, 8'h10, 8'hA5, 0, 8'h10, 8'h00, 24'hA5A500, 24'h000000, 0);
      op(0, 0, 8'h10, 8'h00, 0, 8'h10, 8'h00, 24'hA5A5A5, 24'hA5A5A5, 0);
      op(0, 1, 8'h20, 8'h11, 0, 8'h00, 8'h00, 24'h111100, 24'h000000, 0);
      op(0, 1, 8'h20, 8'h3C, 0, 8'h20, 8'h00, 24'h3C3C11, 24'h111111, 0);
      op(0, 0, 8'h20, 8'h00, 0, 8'h20, 8'h00, 24'h3C3C3C, 24'h3C3C3C, 0);
      op(0, 1, 8'h40, 8'h01, 1, 8'h40, 8'h02, 24'h000200, 24'h000200, 1);
      op(0, 0, 8'h40, 8'h00, 0, 8'h40, 8'h00, 24'h000201, 24'h000201, 0);
      op(0, 1, 8'h50, 8'h77, 1, 8'h51, 8'h88, 24'h777700, 24'h888800, 0);
      op(0, 0, 8'h50, 8'h00, 0, 8'h51, 8'h00, 24'h777777, 24'h888888, 0);
      op(0, 0, 8'h05, 8'h00, 1, 8'h05, 8'hFF, 24'h000000, 24'hFFFF00, 0);
      op(0, 0, 8'h05, 8'h00, 0, 8'h10, 8'h00, 24'hFFFFFF, 24'hA5A5A5, 0);
      op(1, 0, 8'h05, 8'h00, 0, 8'h10, 8'h00, 24'h000000, 24'h000000, 0);
      @(posedge clk);
      #1;
      i0.we_a = 1'b1; i0.addr_a = 8'h05; i0.wdata_a = 8'h99;
      i0.we_b = 1'b1; i0.addr_b = 8'h05; i0.wdata_b = 8'h66;
      count_busy("init clear");
      op(0, 0, 8'h05, 8'h00, 0, 8'h10, 8'h00, 24'h000000, 24'h000000, 0);
      op(0, 1, 8'h30, 8'h5A, 0, 8'h30, 8'h00, 24'h5A5A00, 24'h000000, 0);
      op(0, 0, 8'h30, 8'h00, 0, 8'h30, 8'h00, 24'h5A5A5A, 24'h5A5A5A, 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      rst_chk("reset mid-access");
      @(negedge clk) rst_n = 1'b1;
      count_busy("clear after reset 1");
      op(0, 0, 8'h30, 8'h00, 0, 8'h50, 8'h00, 24'h000000, 24'h000000, 0);
      op(1, 0, 8'h20, 8'h00, 0, 8'h51, 8'h00, 24'h000000, 24'h000000, 0);
      @(posedge clk);
      repeat (100) @(posedge clk);
      #3;
      rst_n = 1'b0;
      rst_chk("reset mid-clear");
      @(negedge clk) rst_n = 1'b1;
      count_busy("clear after reset 2");
      op(0, 0, 8'h10, 8'h00, 0, 8'h05, 8'h00, 24'h000000, 24'h000000, 0);
      @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
